led_pwm_breathe: RTL and testbench

- PWM generator with a breathing-duty sequencer that drives a board LED directly.
- It sits downstream of the system clock and replaces the plain toggle-style LED driver.
- Two modes: fixed duty, loaded by a host or test logic, or an autonomous triangular duty ramp ("breathing").
- Duty changes are double-buffered and take effect only at PWM frame boundaries, so no glitch frames occur.

---
 rtl/led_pwm_breathe.sv | 194 +++++++++++++++++++
 tb/tb_led_pwm_breathe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_breathe.sv
// led_pwm_breathe: frame-synchronous PWM LED driver
// with fixed-duty and triangular breathing modes.
module led_pwm_breathe #(
  parameter int PRESCALE        = 250,
  parameter int PERIOD          = 100,
  parameter int FRAMES_PER_STEP = 5,
  parameter int DW              = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [DW-1:0] duty_in,
  input  logic          duty_load,
  output logic          led,
  output logic [DW-1:0] duty_cur,
  output logic          frame_tick,
  output logic          peak,
  output logic          trough
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [DW-1:0] PWM_MAX  = DW'(PERIOD - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PERIOD);
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [FW-1:0] FR_MAX   = FW'(FRAMES_PER_STEP - 1);
  localparam logic [FW-1:0] FR_ONE   = FW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP_UP,
    S_RAMP_DOWN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pre_cnt;
  logic [DW-1:0] r_pwm_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [FW-1:0] w_frame_cnt_nxt;
  logic [DW-1:0] r_duty_active;
  logic [DW-1:0] w_duty_nxt;
  logic [DW-1:0] r_duty_shadow;
  logic          r_led;
  logic          r_frame_tick;
  logic          r_peak;
  logic          r_trough;
  logic          w_peak_nxt;
  logic          w_trough_nxt;

  logic          w_step_tick;
  logic          w_frame_end;
  logic          w_step_due;
  logic [DW-1:0] w_duty_up;
  logic [DW-1:0] w_duty_dn;
  logic [DW-1:0] w_duty_clamp;

  assign w_step_tick = en && (r_pre_cnt == PRE_MAX);
  assign w_frame_end = w_step_tick && (r_pwm_cnt == PWM_MAX);
  assign w_step_due  = (r_frame_cnt == FR_MAX);

  // Saturating neighbours keep the duty inside 0..PERIOD.
  assign w_duty_up = (r_duty_active >= DUTY_MAX) ?
                     DUTY_MAX : r_duty_active + D_ONE;
  assign w_duty_dn = (r_duty_active == '0) ?
                     '0 : r_duty_active - D_ONE;
  assign w_duty_clamp = (duty_in > DUTY_MAX) ?
                        DUTY_MAX : duty_in;

  // Prescaler: divides clk down to one PWM step.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_pre_cnt <= '0;
    end else if (r_pre_cnt == PRE_MAX) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_ONE;
    end
  end

  // PWM step counter; disabling restarts the frame at 0.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_pwm_cnt <= '0;
    end else if (w_step_tick) begin
      if (r_pwm_cnt == PWM_MAX) begin
        r_pwm_cnt <= '0;
      end else begin
        r_pwm_cnt <= r_pwm_cnt + D_ONE;
      end
    end
  end

  // Shadow duty: host writes land here, clamped to PERIOD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_shadow <= '0;
    end else if (duty_load) begin
      r_duty_shadow <= w_duty_clamp;
    end
  end

  // Registered LED compare and frame boundary pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led        <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_led        <= en && (r_pwm_cnt < r_duty_active);
      r_frame_tick <= w_frame_end;
    end
  end

  // Sequencer state, active duty and limit pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= '0;
      r_duty_active <= '0;
      r_peak        <= 1'b0;
      r_trough      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_duty_active <= w_duty_nxt;
      r_peak        <= w_peak_nxt;
      r_trough      <= w_trough_nxt;
    end
  end

  // Next-state logic; everything moves only on frame_end.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_duty_nxt      = r_duty_active;
    w_peak_nxt      = 1'b0;
    w_trough_nxt    = 1'b0;
    if (w_frame_end) begin
      if (!mode) begin
        w_state_nxt     = S_IDLE;
        w_frame_cnt_nxt = '0;
        w_duty_nxt      = r_duty_shadow;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            w_state_nxt     = S_RAMP_UP;
            w_frame_cnt_nxt = '0;
          end
          S_RAMP_UP: begin
            if (w_step_due) begin
              w_frame_cnt_nxt = '0;
              w_duty_nxt      = w_duty_up;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + FR_ONE;
            end
            if (w_duty_nxt >= DUTY_MAX) begin
              w_state_nxt = S_RAMP_DOWN;
              w_peak_nxt  = 1'b1;
            end
          end
          S_RAMP_DOWN: begin
            if (w_step_due) begin
              w_frame_cnt_nxt = '0;
              w_duty_nxt      = w_duty_dn;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + FR_ONE;
            end
            if (w_duty_nxt == '0) begin
              w_state_nxt  = S_RAMP_UP;
              w_trough_nxt = 1'b1;
            end
          end
          default: begin
            w_state_nxt     = S_IDLE;
            w_frame_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

  assign led        = r_led;
  assign duty_cur   = r_duty_active;
  assign frame_tick = r_frame_tick;
  assign peak       = r_peak;
  assign trough     = r_trough;

endmodule

// File: tb/tb_led_pwm_breathe.sv
// tb_led_pwm_breathe: directed vectors and corner
// sequences for led_pwm_breathe (20 clk frames).
module tb_led_pwm_breathe;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [DW-1:0] duty_in;
  logic          duty_load;
  logic          led;
  logic [DW-1:0] duty_cur;
  logic          frame_tick;
  logic          peak;
  logic          trough;

  led_pwm_breathe #(
    .PRESCALE(2),
    .PERIOD(10),
    .FRAMES_PER_STEP(2),
    .DW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .duty_in(duty_in),
    .duty_load(duty_load),
    .led(led),
    .duty_cur(duty_cur),
    .frame_tick(frame_tick),
    .peak(peak),
    .trough(trough)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stray = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] din;
    int            exp_duty;
    int            exp_high;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_ft(input string name,
                         output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      n++;
      if (!frame_tick && (peak || trough)) stray++;
      if (frame_tick) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s act=no_frame_tick exp=frame_tick",
               name);
    end
  endtask

  task automatic load(input logic [DW-1:0] v);
    duty_in   = v;
    duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int hi;
    int ftc;
    int last_ft;
    int first;
    int last;
    int ftidx;
    int exp_d;
    int pk_cyc0;
    int pk_cyc1;

    vt[0] = '{8'd3,   3,  6};
    vt[1] = '{8'd0,   0,  0};
    vt[2] = '{8'd10,  10, 20};
    vt[3] = '{8'd200, 10, 20};
    vt[4] = '{8'd7,   7,  14};
    vt[5] = '{8'd3,   3,  6};

    rst       = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    duty_in   = '0;
    duty_load = 1'b0;
    pk_cyc0   = 0;
    pk_cyc1   = 0;
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_duty", int'(duty_cur), 0);
    chk("reset_ft", int'(frame_tick), 0);
    chk("reset_peak", int'(peak), 0);
    chk("reset_trough", int'(trough), 0);

    // Fixed duty, extremes and clamp.
    rst = 1'b0;
    en  = 1'b1;
    for (int v = 0; v < 6; v++) begin
      load(vt[v].din);
      wait_ft($sformatf("vec%0d_ft", v), ok);
      if (ok) begin
        chk($sformatf("vec%0d_duty", v),
            int'(duty_cur), vt[v].exp_duty);
        hi = 0;
        ftc = 0;
        last_ft = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          hi += int'(led);
          ftc += int'(frame_tick);
          if (i == 19) last_ft = int'(frame_tick);
        end
        chk($sformatf("vec%0d_high", v), hi, vt[v].exp_high);
        chk($sformatf("vec%0d_ftcnt", v), ftc, 1);
        chk($sformatf("vec%0d_ft20", v), last_ft, 1);
      end
    end

    // Load coinciding with frame_end (shadow 3 -> 7).
    repeat (19) @(negedge clk);
    duty_in   = 8'd7;
    duty_load = 1'b1;
    @(negedge clk);
    duty_load = 1'b0;
    chk("coinc_ft", int'(frame_tick), 1);
    chk("coinc_hold", int'(duty_cur), 3);
    wait_ft("coinc_ft2", ok);
    chk("coinc_new", int'(duty_cur), 7);

    // Enable drop mid-frame at duty 5.
    load(8'd5);
    wait_ft("en_ft", ok);
    chk("en_duty", int'(duty_cur), 5);
    repeat (3) @(negedge clk);
    chk("en_led_on", int'(led), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_led_off", int'(led), 0);
    hi = 0;
    ftc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hi += int'(led);
      ftc += int'(frame_tick);
    end
    chk("en_off_led", hi, 0);
    chk("en_off_ft", ftc, 0);
    chk("en_off_duty", int'(duty_cur), 5);
    en = 1'b1;
    first = -1;
    last = -1;
    ftidx = -1;
    hi = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (led && i <= 20) begin
        hi++;
        if (first < 0) first = i;
        last = i;
      end
      if (frame_tick && ftidx < 0) ftidx = i;
    end
    chk("reen_start", int'(first >= 1 && first <= 2), 1);
    chk("reen_run", hi, 10);
    chk("reen_contig", last - first + 1, 10);
    chk("reen_ft", ftidx, 20);

    // Breathe from duty 0 through peak, trough, peak.
    load(8'd0);
    wait_ft("br_pre", ok);
    chk("br_start", int'(duty_cur), 0);
    mode = 1'b1;
    stray = 0;
    for (int f = 1; f <= 69; f++) begin
      wait_ft($sformatf("br_ft%0d", f), ok);
      if (f <= 21) exp_d = (f - 1) / 2;
      else if (f <= 41) exp_d = 10 - (f - 21) / 2;
      else if (f <= 61) exp_d = (f - 41) / 2;
      else exp_d = 10 - (f - 61) / 2;
      chk($sformatf("br_duty%0d", f), int'(duty_cur), exp_d);
      chk($sformatf("br_peak%0d", f), int'(peak),
          int'(f == 21 || f == 61));
      chk($sformatf("br_trough%0d", f), int'(trough),
          int'(f == 41));
      if (f == 21) pk_cyc0 = cyc;
      if (f == 61) pk_cyc1 = cyc;
    end
    chk("br_spacing", pk_cyc1 - pk_cyc0, 800);
    chk("br_stray", stray, 0);

    // Reset while ramping down at duty 6.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_led", int'(led), 0);
    chk("rst_duty", int'(duty_cur), 0);
    chk("rst_ft", int'(frame_tick), 0);
    chk("rst_pulse", int'(peak || trough), 0);
    stray = 0;
    for (int g = 1; g <= 5; g++) begin
      wait_ft($sformatf("rr_ft%0d", g), ok);
      chk($sformatf("rr_duty%0d", g), int'(duty_cur),
          (g - 1) / 2);
      chk($sformatf("rr_pulse%0d", g),
          int'(peak || trough), 0);
    end
    chk("rr_stray", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
